// File: rtl/exc_pkg.sv
// Shared definitions for the MEM-stage exception initiator:
// cause codes, exc_vec bit positions, FSM states and the report bundle.
package exc_pkg;

    localparam int EXC_VEC_W = 11;

    localparam logic [31:0] EXC_NONE = 32'h00;
    localparam logic [31:0] EXC_INT  = 32'h01;
    localparam logic [31:0] EXC_ADEL = 32'h04;
    localparam logic [31:0] EXC_ADES = 32'h05;
    localparam logic [31:0] EXC_SYS  = 32'h08;
    localparam logic [31:0] EXC_BP   = 32'h09;
    localparam logic [31:0] EXC_RI   = 32'h0A;
    localparam logic [31:0] EXC_OV   = 32'h0C;
    localparam logic [31:0] EXC_ERET = 32'h0E;
    localparam logic [31:0] EXC_AUX0 = 32'h10;
    localparam logic [31:0] EXC_AUX1 = 32'h11;
    localparam logic [31:0] EXC_AUX2 = 32'h12;
    localparam logic [31:0] EXC_AUX3 = 32'h13;

    localparam int V_ADEL_IF = 0;
    localparam int V_RI      = 1;
    localparam int V_OV      = 2;
    localparam int V_SYS     = 3;
    localparam int V_BRK     = 4;
    localparam int V_ERET    = 5;
    localparam int V_AUX0    = 6;
    localparam int V_AUX1    = 7;
    localparam int V_AUX2    = 8;
    localparam int V_AUX3    = 9;
    localparam int V_ADEL_LD = 10;

    localparam logic [31:0] DEF_RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] DEF_GEN_OFS    = 32'h0000_0180;
    localparam logic [31:0] DEF_REFILL_OFS = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COMMIT
    } state_t;

    typedef struct packed {
        logic [31:0] code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic [31:0] tgt;
        logic        tlb;
        logic        load;
    } rpt_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational cause picker: selects the highest-priority cause and
// builds the full report (code, pc, delay slot, bad addr, target, tlb).
// Ports: exc_vec/ades/tlbmiss/load/int_pend/exl flags, pc/mem_addr/epc/ebase
// values in; any (some cause present) and rpt (report bundle) out.
module exc_prio_enc
    import exc_pkg::*;
#(
    parameter logic [31:0] GEN_OFS    = DEF_GEN_OFS,
    parameter logic [31:0] REFILL_OFS = DEF_REFILL_OFS
) (
    input  logic [EXC_VEC_W-1:0] exc_vec,
    input  logic                 ades,
    input  logic                 tlbmiss,
    input  logic                 load,
    input  logic                 int_pend,
    input  logic                 exl,
    input  logic                 in_delay_slot,
    input  logic [31:0]          pc,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          epc,
    input  logic [31:0]          ebase,
    output logic                 any,
    output rpt_t                 rpt
);

    always_comb begin
        rpt      = '0;
        rpt.pc   = pc;
        rpt.ds   = in_delay_slot;
        rpt.tgt  = ebase + GEN_OFS;
        any      = 1'b1;
        if (int_pend) begin
            rpt.code = EXC_INT;
        end else if (exc_vec[V_ADEL_IF]) begin
            rpt.code = EXC_ADEL;
            rpt.bad  = pc;
        end else if (exc_vec[V_RI]) begin
            rpt.code = EXC_RI;
        end else if (exc_vec[V_OV]) begin
            rpt.code = EXC_OV;
        end else if (exc_vec[V_SYS]) begin
            rpt.code = EXC_SYS;
        end else if (exc_vec[V_BRK]) begin
            rpt.code = EXC_BP;
        end else if (exc_vec[V_ERET]) begin
            rpt.code = EXC_ERET;
            rpt.tgt  = epc;
        end else if (exc_vec[V_AUX0]) begin
            rpt.code = EXC_AUX0;
        end else if (exc_vec[V_AUX1]) begin
            rpt.code = EXC_AUX1;
        end else if (exc_vec[V_AUX2]) begin
            rpt.code = EXC_AUX2;
        end else if (exc_vec[V_AUX3]) begin
            rpt.code = EXC_AUX3;
        end else if (exc_vec[V_ADEL_LD]) begin
            rpt.code = EXC_ADEL;
            rpt.bad  = mem_addr;
        end else if (ades) begin
            rpt.code = EXC_ADES;
            rpt.bad  = mem_addr;
        end else if (tlbmiss) begin
            // TLB miss reports type 0; CP0 keys off tlbmiss instead.
            rpt.code = EXC_NONE;
            rpt.bad  = mem_addr;
            rpt.tlb  = 1'b1;
            rpt.load = load;
            // Refill vector only when not already in exception level.
            if (!exl) begin
                rpt.tgt = ebase + REFILL_OFS;
            end
        end else begin
            any = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception initiator: captures a cause, waits out memory,
// then issues one registered report/flush/redirect cycle to CP0 and fetch.
// Ports: clk/rst_n; MEM instr info, flags, mem_busy_i, CP0 status/cause/
// epc/ebase in; CP0 report, flush_o, stall_o, new_pc_o/new_pc_valid_o out.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] GEN_OFS    = DEF_GEN_OFS,
    parameter logic [31:0] REFILL_OFS = DEF_REFILL_OFS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic [31:0]          pc_i,
    input  logic                 in_delay_slot_i,
    input  logic [EXC_VEC_W-1:0] exc_vec_i,
    input  logic                 ades_i,
    input  logic                 tlbmiss_i,
    input  logic                 load_i,
    input  logic [31:0]          mem_addr_i,
    input  logic                 mem_busy_i,
    input  logic [31:0]          status_i,
    input  logic [31:0]          cause_i,
    input  logic [31:0]          epc_i,
    input  logic [31:0]          ebase_i,
    output logic [31:0]          exceptionType_o,
    output logic [31:0]          exceptionAddr_o,
    output logic                 in_delay_slot_o,
    output logic [31:0]          badVaddr_o,
    output logic                 tlbmiss_o,
    output logic                 load_o,
    output logic                 flush_o,
    output logic                 stall_o,
    output logic [31:0]          new_pc_o,
    output logic                 new_pc_valid_o
);

    state_t state;
    rpt_t   cur;
    rpt_t   cap;
    rpt_t   sel;
    logic   any;
    logic   int_pend;
    logic   hit;
    logic   report;
    logic   unused_bits;

    assign int_pend = (|(cause_i[15:8] & status_i[15:8]))
                    & status_i[0] & ~status_i[1];

    assign unused_bits = ^{status_i[31:16], status_i[7:2],
                           cause_i[31:16], cause_i[7:0]};

    exc_prio_enc #(
        .GEN_OFS    (GEN_OFS),
        .REFILL_OFS (REFILL_OFS)
    ) u_enc (
        .exc_vec       (exc_vec_i),
        .ades          (ades_i),
        .tlbmiss       (tlbmiss_i),
        .load          (load_i),
        .int_pend      (int_pend),
        .exl           (status_i[1]),
        .in_delay_slot (in_delay_slot_i),
        .pc            (pc_i),
        .mem_addr      (mem_addr_i),
        .epc           (epc_i),
        .ebase         (ebase_i),
        .any           (any),
        .rpt           (cur)
    );

    assign hit     = valid_i & any & (state == IDLE);
    assign stall_o = hit | (state == WAIT);

    // A hit with memory idle reports straight from the encoder;
    // after a wait the captured copy is used.
    assign sel    = (state == IDLE) ? cur : cap;
    assign report = ~mem_busy_i & (hit | (state == WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cap             <= '0;
            exceptionType_o <= '0;
            exceptionAddr_o <= '0;
            in_delay_slot_o <= 1'b0;
            badVaddr_o      <= '0;
            tlbmiss_o       <= 1'b0;
            load_o          <= 1'b0;
            flush_o         <= 1'b0;
            new_pc_o        <= RESET_PC;
            new_pc_valid_o  <= 1'b0;
        end else begin
            exceptionType_o <= '0;
            tlbmiss_o       <= 1'b0;
            load_o          <= 1'b0;
            flush_o         <= 1'b0;
            new_pc_valid_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        cap   <= cur;
                        state <= mem_busy_i ? WAIT : COMMIT;
                    end
                end
                WAIT: begin
                    if (!mem_busy_i) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (report) begin
                exceptionType_o <= sel.code;
                exceptionAddr_o <= sel.pc;
                in_delay_slot_o <= sel.ds;
                badVaddr_o      <= sel.bad;
                tlbmiss_o       <= sel.tlb;
                load_o          <= sel.load;
                flush_o         <= 1'b1;
                new_pc_o        <= sel.tgt;
                new_pc_valid_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: priority-table model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] pc_i;
    logic        in_delay_slot_i;
    logic [10:0] exc_vec_i;
    logic        ades_i;
    logic        tlbmiss_i;
    logic        load_i;
    logic [31:0] mem_addr_i;
    logic        mem_busy_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic [31:0] ebase_i;
    logic [31:0] exceptionType_o;
    logic [31:0] exceptionAddr_o;
    logic        in_delay_slot_o;
    logic [31:0] badVaddr_o;
    logic        tlbmiss_o;
    logic        load_o;
    logic        flush_o;
    logic        stall_o;
    logic [31:0] new_pc_o;
    logic        new_pc_valid_o;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_i         (valid_i),
        .pc_i            (pc_i),
        .in_delay_slot_i (in_delay_slot_i),
        .exc_vec_i       (exc_vec_i),
        .ades_i          (ades_i),
        .tlbmiss_i       (tlbmiss_i),
        .load_i          (load_i),
        .mem_addr_i      (mem_addr_i),
        .mem_busy_i      (mem_busy_i),
        .status_i        (status_i),
        .cause_i         (cause_i),
        .epc_i           (epc_i),
        .ebase_i         (ebase_i),
        .exceptionType_o (exceptionType_o),
        .exceptionAddr_o (exceptionAddr_o),
        .in_delay_slot_o (in_delay_slot_o),
        .badVaddr_o      (badVaddr_o),
        .tlbmiss_o       (tlbmiss_o),
        .load_o          (load_o),
        .flush_o         (flush_o),
        .stall_o         (stall_o),
        .new_pc_o        (new_pc_o),
        .new_pc_valid_o  (new_pc_valid_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic        any;
        logic [31:0] code;
        logic [31:0] addr;
        logic        ds;
        logic [31:0] bad;
        logic [31:0] tgt;
        logic        tlb;
        logic        ld;
    } mrep_t;

    // Causes in priority order: int, exc_vec[0..10], ades, tlbmiss.
    localparam logic [31:0] CODES [14] = '{
        32'h01, 32'h04, 32'h0A, 32'h0C, 32'h08, 32'h09, 32'h0E,
        32'h10, 32'h11, 32'h12, 32'h13, 32'h04, 32'h05, 32'h00
    };

    function automatic mrep_t model_rep();
        mrep_t       r;
        logic [13:0] f;
        logic        ip;
        int          idx;
        ip  = (|(cause_i[15:8] & status_i[15:8])) && status_i[0]
              && !status_i[1];
        f   = {tlbmiss_i, ades_i, exc_vec_i, ip};
        idx = -1;
        for (int i = 13; i >= 0; i--) begin
            if (f[i]) idx = i;
        end
        r      = '0;
        r.any  = (idx >= 0);
        r.addr = pc_i;
        r.ds   = in_delay_slot_i;
        if (r.any) begin
            r.code = CODES[idx];
            r.tlb  = (idx == 13);
            r.ld   = (idx == 13) && load_i;
            if (idx == 1) r.bad = pc_i;
            else if (idx >= 11) r.bad = mem_addr_i;
            else r.bad = 32'h0;
            if (idx == 6) r.tgt = epc_i;
            else if (idx == 13 && !status_i[1]) r.tgt = ebase_i;
            else r.tgt = ebase_i + 32'h180;
        end
        return r;
    endfunction

    mrep_t cur;
    mrep_t held;
    mrep_t pub;
    logic  m_wait;
    logic  m_rep;
    logic  fire;

    always_comb cur = model_rep();
    assign pub  = m_wait ? held : cur;
    assign fire = !m_rep && !mem_busy_i
                  && (m_wait || (valid_i && cur.any));

    logic [31:0] e_type, e_addr, e_bad, e_npc;
    logic        e_ds, e_tlb, e_ld, e_flush, e_npv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait  <= 1'b0;
            m_rep   <= 1'b0;
            held    <= '0;
            e_type  <= '0;
            e_addr  <= '0;
            e_ds    <= 1'b0;
            e_bad   <= '0;
            e_tlb   <= 1'b0;
            e_ld    <= 1'b0;
            e_flush <= 1'b0;
            e_npc   <= 32'hBFC0_0000;
            e_npv   <= 1'b0;
        end else begin
            e_type  <= '0;
            e_tlb   <= 1'b0;
            e_ld    <= 1'b0;
            e_flush <= 1'b0;
            e_npv   <= 1'b0;
            m_rep   <= fire;
            if (!m_rep && !m_wait && valid_i && cur.any) begin
                held   <= cur;
                m_wait <= mem_busy_i;
            end else if (m_wait && !mem_busy_i) begin
                m_wait <= 1'b0;
            end
            if (fire) begin
                e_type  <= pub.code;
                e_addr  <= pub.addr;
                e_ds    <= pub.ds;
                e_bad   <= pub.bad;
                e_tlb   <= pub.tlb;
                e_ld    <= pub.ld;
                e_flush <= 1'b1;
                e_npc   <= pub.tgt;
                e_npv   <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_type", exceptionType_o, e_type);
        chk("m_addr", exceptionAddr_o, e_addr);
        chk("m_ds", 32'(in_delay_slot_o), 32'(e_ds));
        chk("m_bad", badVaddr_o, e_bad);
        chk("m_tlb", 32'(tlbmiss_o), 32'(e_tlb));
        chk("m_load", 32'(load_o), 32'(e_ld));
        chk("m_flush", 32'(flush_o), 32'(e_flush));
        chk("m_npc", new_pc_o, e_npc);
        chk("m_npv", 32'(new_pc_valid_o), 32'(e_npv));
        chk("m_stall", 32'(stall_o),
            32'(m_wait || (!m_rep && valid_i && cur.any)));
    end

    // ---------------- stimulus ----------------
    task automatic go();
        @(posedge clk);
        #2;
    endtask

    task automatic at();
        @(negedge clk);
    endtask

    task automatic idle();
        valid_i         = 1'b0;
        exc_vec_i       = '0;
        ades_i          = 1'b0;
        tlbmiss_i       = 1'b0;
        load_i          = 1'b0;
        mem_busy_i      = 1'b0;
        in_delay_slot_i = 1'b0;
    endtask

    int n;

    initial begin
        rst_n      = 1'b0;
        idle();
        pc_i       = '0;
        mem_addr_i = '0;
        status_i   = '0;
        cause_i    = '0;
        epc_i      = '0;
        ebase_i    = 32'h8000_0000;
        at();
        chk("rst_npc", new_pc_o, 32'hBFC0_0000);
        chk("rst_flush", 32'(flush_o), 32'h0);
        chk("rst_type", exceptionType_o, 32'h0);
        go();
        rst_n = 1'b1;

        // syscall, single-cycle report
        go();
        pc_i      = 32'h8000_0100;
        exc_vec_i = 11'h008;
        valid_i   = 1'b1;
        go();
        idle();
        at();
        chk("t1_type", exceptionType_o, 32'h8);
        chk("t1_addr", exceptionAddr_o, 32'h8000_0100);
        chk("t1_flush", 32'(flush_o), 32'h1);
        chk("t1_npc", new_pc_o, 32'h8000_0180);
        chk("t1_npv", 32'(new_pc_valid_o), 32'h1);
        at();
        chk("t1_flush_once", 32'(flush_o), 32'h0);

        // ov beats syscall, delay slot reported
        go();
        exc_vec_i       = 11'h00C;
        in_delay_slot_i = 1'b1;
        valid_i         = 1'b1;
        go();
        idle();
        at();
        chk("t2_type", exceptionType_o, 32'hC);
        chk("t2_ds", 32'(in_delay_slot_o), 32'h1);

        // interrupt wins, masked by EXL
        go();
        status_i  = 32'h0000_0401;
        cause_i   = 32'h0000_0400;
        exc_vec_i = 11'h008;
        valid_i   = 1'b1;
        go();
        idle();
        at();
        chk("t3_int", exceptionType_o, 32'h1);
        go();
        status_i  = 32'h0000_0403;
        exc_vec_i = 11'h008;
        valid_i   = 1'b1;
        go();
        idle();
        at();
        chk("t3_exl", exceptionType_o, 32'h8);
        status_i = '0;
        cause_i  = '0;

        // store address error behind a busy memory
        go();
        n          = 0;
        mem_addr_i = 32'h1234_5671;
        ades_i     = 1'b1;
        valid_i    = 1'b1;
        mem_busy_i = 1'b1;
        at();
        n += int'(stall_o);
        go();
        valid_i = 1'b0;
        ades_i  = 1'b0;
        at();
        n += int'(stall_o);
        go();
        at();
        n += int'(stall_o);
        go();
        mem_busy_i = 1'b0;
        at();
        n += int'(stall_o);
        go();
        at();
        chk("t4_stall_cycles", 32'(n), 32'd4);
        chk("t4_type", exceptionType_o, 32'h5);
        chk("t4_bad", badVaddr_o, 32'h1234_5671);
        chk("t4_flush", 32'(flush_o), 32'h1);
        chk("t4_stall_off", 32'(stall_o), 32'h0);

        // TLB-miss load: refill vector, then general with EXL
        go();
        mem_addr_i = 32'h0040_0010;
        tlbmiss_i  = 1'b1;
        load_i     = 1'b1;
        valid_i    = 1'b1;
        go();
        idle();
        at();
        chk("t5_type", exceptionType_o, 32'h0);
        chk("t5_tlb", 32'(tlbmiss_o), 32'h1);
        chk("t5_load", 32'(load_o), 32'h1);
        chk("t5_npc", new_pc_o, 32'h8000_0000);
        chk("t5_bad", badVaddr_o, 32'h0040_0010);
        go();
        status_i  = 32'h0000_0002;
        tlbmiss_i = 1'b1;
        load_i    = 1'b1;
        valid_i   = 1'b1;
        go();
        idle();
        at();
        chk("t5_npc_exl", new_pc_o, 32'h8000_0180);
        status_i = '0;

        // eret redirects to EPC
        go();
        epc_i     = 32'h8000_2000;
        exc_vec_i = 11'h020;
        valid_i   = 1'b1;
        go();
        idle();
        at();
        chk("t6_type", exceptionType_o, 32'hE);
        chk("t6_npc", new_pc_o, 32'h8000_2000);

        // held hit: ignored in COMMIT, taken again right after
        go();
        pc_i      = 32'h8000_0200;
        exc_vec_i = 11'h008;
        valid_i   = 1'b1;
        go();
        at();
        chk("t7_flush_a", 32'(flush_o), 32'h1);
        chk("t7_commit_stall", 32'(stall_o), 32'h0);
        go();
        at();
        chk("t7_gap", 32'(flush_o), 32'h0);
        chk("t7_rehit_stall", 32'(stall_o), 32'h1);
        go();
        idle();
        at();
        chk("t7_flush_b", 32'(flush_o), 32'h1);

        // reset while waiting discards the report
        go();
        exc_vec_i  = 11'h008;
        valid_i    = 1'b1;
        mem_busy_i = 1'b1;
        go();
        valid_i   = 1'b0;
        exc_vec_i = '0;
        at();
        chk("t8_wait_stall", 32'(stall_o), 32'h1);
        go();
        rst_n      = 1'b0;
        mem_busy_i = 1'b0;
        at();
        chk("t8_rst_flush", 32'(flush_o), 32'h0);
        chk("t8_rst_type", exceptionType_o, 32'h0);
        chk("t8_rst_npc", new_pc_o, 32'hBFC0_0000);
        chk("t8_rst_addr", exceptionAddr_o, 32'h0);
        chk("t8_rst_stall", 32'(stall_o), 32'h0);
        go();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at();
            chk("t8_no_flush", 32'(flush_o), 32'h0);
            chk("t8_no_npv", 32'(new_pc_valid_o), 32'h0);
        end

        go();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
